// File: rtl/risc16b_mmio.sv
// Memory-mapped I/O block for the risc16b CPU: LED register, free-running timer,
// and a write-only UART transmitter with a busy flag, all in the 0x7fxx window.
module risc16b_mmio #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_addr,
  input  logic        d_oe,
  input  logic [1:0]  d_we,
  input  logic [15:0] d_dout,
  output logic        io_sel,
  output logic [15:0] io_rdata,
  output logic [15:0] led,
  output logic        uart_tx
);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  localparam logic [6:0] OFF_LED    = 7'd0;
  localparam logic [6:0] OFF_TIMER  = 7'd1;
  localparam logic [6:0] OFF_TXDATA = 7'd2;
  localparam logic [6:0] OFF_STATUS = 7'd3;

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] led_q, led_d;
  logic [15:0] timer_q, timer_d;

  logic [6:0]  off;
  logic        busy;
  logic        tx_accept;
  logic        baud_done;
  logic        unused_addr_lsb;

  assign io_sel          = (d_addr[15:8] == 8'h7f);
  assign off             = d_addr[7:1];
  assign unused_addr_lsb = d_addr[0];
  assign busy            = (state_q != TX_IDLE);
  assign baud_done       = (baud_q == BAUD_LAST);
  assign tx_accept       = io_sel && (off == OFF_TXDATA) && d_we[1] && !busy;
  assign led             = led_q;

  // Register file: LED byte lanes and the timer, whose clear beats the increment.
  always_comb begin
    led_d   = led_q;
    timer_d = timer_q + 16'd1;
    if (io_sel && (off == OFF_LED)) begin
      if (d_we[0]) led_d[15:8] = d_dout[15:8];
      if (d_we[1]) led_d[7:0]  = d_dout[7:0];
    end
    if (io_sel && (off == OFF_TIMER) && (d_we != 2'b00)) timer_d = 16'h0000;
  end

  always_comb begin
    io_rdata = 16'h0000;
    if (io_sel && d_oe) begin
      case (off)
        OFF_LED:    io_rdata = led_q;
        OFF_TIMER:  io_rdata = timer_q;
        OFF_STATUS: io_rdata = {15'b0, busy};
        default:    io_rdata = 16'h0000;
      endcase
    end
  end

  // Transmitter: baud_q counts cycles within a bit, bit_q selects the data bit.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    uart_tx = 1'b1;
    case (state_q)
      TX_IDLE: begin
        baud_d = 16'd0;
        bit_d  = 3'd0;
        if (tx_accept) begin
          state_d = TX_START;
          shift_d = d_dout[7:0];
        end
      end
      TX_START: begin
        uart_tx = 1'b0;
        if (baud_done) begin
          baud_d  = 16'd0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      TX_DATA: begin
        uart_tx = shift_q[bit_q];
        if (baud_done) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = TX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      TX_STOP: begin
        if (baud_done) begin
          baud_d  = 16'd0;
          state_d = TX_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      led_q   <= 16'h0000;
      timer_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      led_q   <= led_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: tb/tb_risc16b_mmio.sv
// Bench for risc16b_mmio: directed scenarios plus random bus traffic, all checked
// against a cycle-level model that holds the expected serial line in a queue.
module tb_risc16b_mmio;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_addr;
  logic        d_oe;
  logic [1:0]  d_we;
  logic [15:0] d_dout;
  logic        io_sel;
  logic [15:0] io_rdata;
  logic [15:0] led;
  logic        uart_tx;

  risc16b_mmio #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .d_addr   (d_addr),
    .d_oe     (d_oe),
    .d_we     (d_we),
    .d_dout   (d_dout),
    .io_sel   (io_sel),
    .io_rdata (io_rdata),
    .led      (led),
    .uart_tx  (uart_tx)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_led   = 16'h0000;
  logic [15:0] m_timer = 16'h0000;
  logic        m_busy  = 1'b0;
  logic        m_line  = 1'b1;
  logic [0:0]  exp_q[$];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_rdata();
    logic [15:0] r;
    r = 16'h0000;
    if ((d_addr[15:8] == 8'h7f) && d_oe) begin
      case (d_addr[7:1])
        7'd0:    r = m_led;
        7'd1:    r = m_timer;
        7'd3:    r = {15'b0, m_busy};
        default: r = 16'h0000;
      endcase
    end
    return r;
  endfunction

  // One serial frame: start bit, 8 data bits LSB first, stop bit, each CPB cycles.
  task automatic push_frame(input logic [7:0] b);
    logic v;
    for (int k = 0; k < 10; k++) begin
      v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      for (int c = 0; c < CPB; c++) exp_q.push_back(v);
    end
  endtask

  task automatic check_all();
    check_eq("io_sel", {15'b0, io_sel}, {15'b0, (d_addr[15:8] == 8'h7f)});
    check_eq("led", led, m_led);
    check_eq("uart_tx", {15'b0, uart_tx}, {15'b0, m_line});
    check_eq("io_rdata", io_rdata, exp_rdata());
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [15:0] a, input logic oe, input logic [1:0] we,
                       input logic [15:0] dout);
    d_addr = a;
    d_oe   = oe;
    d_we   = we;
    d_dout = dout;
  endtask

  task automatic step();
    logic       sel, c_rst, was_busy;
    logic [6:0] off;
    logic [1:0] we;
    logic [15:0] dout;
    sel      = (d_addr[15:8] == 8'h7f);
    off      = d_addr[7:1];
    we       = d_we;
    dout     = d_dout;
    c_rst    = rst;
    was_busy = m_busy;
    @(posedge clk);
    if (c_rst) begin
      m_led   = 16'h0000;
      m_timer = 16'h0000;
      exp_q.delete();
      m_busy  = 1'b0;
      m_line  = 1'b1;
    end else begin
      if (sel && off == 7'd0) begin
        if (we[0]) m_led[15:8] = dout[15:8];
        if (we[1]) m_led[7:0]  = dout[7:0];
      end
      if (sel && off == 7'd1 && we != 2'b00) m_timer = 16'h0000;
      else m_timer = m_timer + 16'd1;
      if (sel && off == 7'd2 && we[1] && !was_busy) push_frame(dout[7:0]);
      if (exp_q.size() > 0) begin
        m_line = exp_q.pop_front();
        m_busy = 1'b1;
      end else begin
        m_line = 1'b1;
        m_busy = 1'b0;
      end
    end
    #1;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] bits;
    int         busy_cnt;

    rst = 1'b1;
    drive(16'h0000, 1'b0, 2'b00, 16'h0000);
    repeat (3) step();
    check_eq("rst_led", led, 16'h0000);
    check_eq("rst_uart", {15'b0, uart_tx}, 16'h0001);

    // Timer counts from release of reset.
    rst = 1'b0;
    drive(16'h7f02, 1'b1, 2'b00, 16'h0000);
    step();
    check_eq("timer_post_rst", io_rdata, 16'h0001);
    repeat (6) step();
    check_eq("timer_n7", io_rdata, 16'h0007);

    // Byte-lane LED writes.
    drive(16'h7f00, 1'b0, 2'b01, 16'hA55A);
    step();
    drive(16'h7f00, 1'b0, 2'b10, 16'h1234);
    step();
    check_eq("led_bytes", led, 16'hA534);
    drive(16'h7f00, 1'b1, 2'b00, 16'h0000);
    #1 check_eq("led_read", io_rdata, 16'hA534);

    // Writes outside the window do nothing.
    drive(16'h7e00, 1'b0, 2'b11, 16'hFFFF);
    step();
    check_eq("led_outside", led, 16'hA534);

    // Timer clear overrides increment, then wraps after 65535 more cycles.
    drive(16'h7f02, 1'b0, 2'b01, 16'h0000);
    step();
    drive(16'h7f02, 1'b1, 2'b00, 16'h0000);
    #1 check_eq("timer_clr", io_rdata, 16'h0000);
    step();
    check_eq("timer_clr_plus1", io_rdata, 16'h0001);
    drive(16'h7f02, 1'b0, 2'b11, 16'h0000);
    step();
    drive(16'h7f02, 1'b1, 2'b00, 16'h0000);
    repeat (65535) step();
    check_eq("timer_ffff", io_rdata, 16'hffff);
    step();
    check_eq("timer_wrap", io_rdata, 16'h0000);

    // Frame of 0x55, sampled mid-bit, with busy measured on STATUS.
    drive(16'h7f04, 1'b0, 2'b10, 16'h0055);
    step();
    drive(16'h7f06, 1'b1, 2'b00, 16'h0000);
    #1;
    bits = '0;
    busy_cnt = 0;
    for (int j = 0; j < 45; j++) begin
      if (j < 40 && (j % CPB) == 2) bits[j / CPB] = uart_tx;
      if (io_rdata[0]) busy_cnt++;
      step();
    end
    check_eq("tx55_bits", {6'b0, bits}, {6'b0, 10'b1010101010});
    check_eq("tx55_busy_cycles", 16'(busy_cnt), 16'd40);

    // Low-lane-only write must not start a frame.
    drive(16'h7f04, 1'b0, 2'b01, 16'h00FF);
    step();
    check_eq("tx_we0_ignored", {15'b0, uart_tx}, 16'h0001);

    // Mid-frame write is ignored; the original byte finishes intact.
    drive(16'h7f04, 1'b0, 2'b10, 16'h00A3);
    step();
    drive(16'h7f06, 1'b1, 2'b00, 16'h0000);
    repeat (10) step();
    drive(16'h7f04, 1'b0, 2'b11, 16'h00FF);
    step();
    drive(16'h7f06, 1'b1, 2'b00, 16'h0000);
    repeat (40) step();
    check_eq("tx_midframe_idle", io_rdata, 16'h0000);

    // Reset mid-frame aborts the frame.
    drive(16'h7f04, 1'b0, 2'b10, 16'h000F);
    step();
    drive(16'h7f06, 1'b1, 2'b00, 16'h0000);
    repeat (15) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_mid_uart", {15'b0, uart_tx}, 16'h0001);
    check_eq("rst_mid_status", io_rdata, 16'h0000);
    check_eq("rst_mid_led", led, 16'h0000);

    // Unmapped offset and out-of-window reads.
    drive(16'h7f08, 1'b1, 2'b00, 16'h0000);
    #1;
    check_eq("rd_7f08", io_rdata, 16'h0000);
    check_eq("sel_7f08", {15'b0, io_sel}, 16'h0001);
    drive(16'h1202, 1'b1, 2'b00, 16'h0000);
    #1;
    check_eq("rd_outside", io_rdata, 16'h0000);
    check_eq("sel_outside", {15'b0, io_sel}, 16'h0000);

    // Random bus traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      logic [1:0]  we;
      a  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : {8'h7f, 8'($urandom_range(0, 11))};
      we = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      drive(a, 1'($urandom_range(0, 1)), we, 16'($urandom));
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/risc16b_mmio.md
RISC16B_MMIO -- requirements
Module: risc16b_mmio

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning UART bit period in clk cycles (50 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port d_addr  input  16  CPU data-bus byte address.
REQ-005 SHALL have port d_oe  input  1  CPU data-bus read enable.
REQ-006 SHALL have port d_we  input  2  byte write enables: bit0 writes d_dout[15:8], bit1 writes d_dout[7:0].
REQ-007 SHALL have port d_dout  input  16  CPU write data.
REQ-008 SHALL have port io_sel  output  1  high when d_addr[15:8] == 8'h7f.
REQ-009 SHALL have port io_rdata  output  16  read data for the I/O window.
REQ-010 SHALL have port led  output  16  LED register.
REQ-011 SHALL have port uart_tx  output  1  serial line, idle high.

Function
REQ-012 SHALL decode io_sel combinationally from d_addr[15:8] == 8'h7f; no access takes effect when io_sel is low.
REQ-013 SHALL map registers by d_addr[7:1]: 0 = LED (rw), 1 = TIMER (rw), 2 = TXDATA (wo), 3 = STATUS (ro); all other offsets read 16'h0000 and ignore writes.
REQ-014 SHALL drive io_rdata combinationally, zero latency: selected register value when io_sel and d_oe are both high, else 16'h0000.
REQ-015 SHALL update LED at the clock edge per byte lane: d_we[0] loads led[15:8] from d_dout[15:8]; d_we[1] loads led[7:0] from d_dout[7:0].
REQ-016 SHALL increment TIMER (16-bit) by 1 every cycle and wrap from 16'hffff to 16'h0000.
REQ-017 SHALL clear TIMER to 16'h0000 at the clock edge of any write to offset 1 with d_we != 0; a clearing write overrides that cycle's increment.
REQ-018 SHALL read TXDATA as 16'h0000.
REQ-019 SHALL read STATUS as {15'b0, busy}, with busy high in any transmitter state other than IDLE.
REQ-020 SHALL accept a TX byte only when busy is low and d_we[1] is high at offset 2, latching d_dout[7:0]; writes with only d_we[0], and any writes while busy, SHALL be ignored.
REQ-021 SHALL implement transmitter FSM IDLE -> START -> DATA -> STOP -> IDLE, with each state lasting exactly CLKS_PER_BIT cycles (DATA lasting 8 x CLKS_PER_BIT).
REQ-022 SHALL drive uart_tx: 1 in IDLE, 0 in START, data bits LSB first in DATA, 1 in STOP.
REQ-023 SHALL set busy and drive uart_tx = 0 in the cycle immediately after the accepting edge.
REQ-024 SHALL return to IDLE (busy = 0) exactly 10 x CLKS_PER_BIT cycles after the accepting edge, so a new byte is accepted no earlier than that cycle.
REQ-025 SHALL serve bus accesses to LED, TIMER and STATUS independently of and concurrently with transmission.

Reset
REQ-026 SHALL, on rst high at a clock edge, set led = 16'h0000, TIMER = 16'h0000, FSM = IDLE, bit counter = 0, baud counter = 0, uart_tx = 1, busy = 0.
REQ-027 SHALL abort any in-progress frame on reset, with uart_tx high from the next cycle.
REQ-028 SHALL ignore bus writes in any cycle where rst is high.
REQ-029 SHALL make TIMER read 16'h0001 one cycle after rst is deasserted.

Verification
REQ-030 SHALL cover: write 16'h7f00 with d_dout = 16'hA55A and d_we = 2'b01, then d_we = 2'b10 with d_dout = 16'h1234 -> led = 16'hA534.
REQ-031 SHALL cover: rst deasserted, read 16'h7f02 N cycles later -> io_rdata = N mod 65536; let TIMER reach 16'hffff -> next cycle 16'h0000.
REQ-032 SHALL cover: increment in the same cycle as a write to 16'h7f02 -> TIMER = 16'h0000 next cycle, then 16'h0001.
REQ-033 SHALL cover: CLKS_PER_BIT = 4, write 16'h0055 to 16'h7f04 -> uart_tx sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles; STATUS = 1 for 40 cycles, then 0.
REQ-034 SHALL cover: write 16'h00FF to 16'h7f04 mid-frame -> ignored, original byte completes unchanged; reset mid-frame -> uart_tx = 1, STATUS = 0 next cycle.
REQ-035 SHALL cover: read 16'h7f08, or any read with d_addr[15:8] != 8'h7f -> io_rdata = 16'h0000; io_sel = 0 outside the window.
